tx_frame_sched: RTL and testbench
=================================

TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

Interface
REQ-001 Parameter BUSY_WAIT, default 4: max clk cycles from tx_data_valid pulse to tx_busy rise before a start timeout is declared; legal range 1..255.
REQ-002 clk  input  1  single clock for all state; rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 alu_out  input  16  ALU result to be sent as two frames.
REQ-005 alu_valid  input  1  level request from ALU path; alu_out stable while high.
REQ-006 rd_data  input  8  register-file read data to be sent as one frame.
REQ-007 rd_valid  input  1  level request from register-read path; rd_data stable while high.
REQ-008 tx_busy  input  1  busy from the UART transmitter.
REQ-009 tx_p_data  output  8  byte presented to the UART transmitter.
REQ-010 tx_data_valid  output  1  one-cycle load strobe to the UART transmitter.
REQ-011 alu_ack  output  1  one-cycle pulse: alu_out captured, requester may drop alu_valid.
REQ-012 rd_ack  output  1  one-cycle pulse: rd_data captured.
REQ-013 sched_busy  output  1  high in every state except IDLE.
REQ-014 tx_err  output  1  one-cycle pulse on start timeout.

Function
REQ-015 States SHALL be IDLE, LOAD, WAIT_START, WAIT_DONE; the encoding is free.
REQ-016 IDLE: a grant SHALL be issued only when a request is high and tx_busy=0. In the same cycle the winner's data SHALL be latched into a 16-bit hold register (rd_data zero-extended), the matching ack SHALL be pulsed, byte_sel SHALL be cleared, and the state SHALL go to LOAD.
REQ-017 Arbitration SHALL be round-robin between ALU and RD. A single requester SHALL always win. When both request, the one not granted last SHALL win. last_grant SHALL reset to RD, so ALU wins the first tie.
REQ-018 LOAD SHALL last exactly one cycle: tx_data_valid=1, tx_p_data = hold[7:0] when byte_sel=0 and hold[15:8] when byte_sel=1, wait counter cleared, then WAIT_START.
REQ-019 tx_p_data SHALL hold its value from LOAD until the next LOAD. It SHALL not change in WAIT_START or WAIT_DONE.
REQ-020 WAIT_START: on tx_busy=1 the state SHALL go to WAIT_DONE. Otherwise the counter SHALL increment. When the counter reaches BUSY_WAIT with tx_busy still 0, the block SHALL pulse tx_err, abandon the remaining bytes of the frame, and go to IDLE.
REQ-021 WAIT_DONE: on tx_busy=0 the frame is complete. For an ALU grant with byte_sel=0, the block SHALL set byte_sel=1 and go to LOAD. In every other case it SHALL go to IDLE.
REQ-022 The ALU result SHALL be sent LSB byte first. The two frames SHALL be back-to-back, with no re-arbitration between them.
REQ-023 The latency from IDLE grant to tx_data_valid SHALL be 1 cycle. The gap between the first frame's busy fall and the second frame's tx_data_valid SHALL be 1 cycle.
REQ-024 Requests arriving outside IDLE SHALL be ignored until IDLE and SHALL not be lost while held high. No ack SHALL be issued outside IDLE.
REQ-025 tx_data_valid, alu_ack, rd_ack and tx_err SHALL each be a single-cycle pulse and SHALL never be high for two consecutive cycles.

Reset
REQ-026 While rst=0, asynchronously: state=IDLE; tx_p_data=8'h00; hold=0; byte_sel=0; counter=0; last_grant=RD; all strobes and sched_busy = 0.
REQ-027 Reset asserted mid-frame SHALL abort immediately with no further tx_data_valid. After release, pending requests SHALL be re-arbitrated from IDLE.
REQ-028 The first grant is permitted on the first rising edge after rst deasserts.

Verification
REQ-029 Single read: rd_data=8'hA5, rd_valid=1, transmitter model raises busy 1 cycle after load for 11 cycles -> rd_ack at edge 1, tx_data_valid with tx_p_data=A5 at edge 2, back to IDLE after busy falls.
REQ-030 ALU result: alu_out=16'h1234 -> frames 8'h34 then 8'h12, exactly two tx_data_valid pulses, one alu_ack, sched_busy high throughout.
REQ-031 Tie after reset: alu_valid=rd_valid=1 with alu_out=16'hBEEF and rd_data=8'h5A -> ALU served first (EF, BE), then RD (5A). Repeating the tie afterwards -> RD served first.
REQ-032 Timeout: transmitter model never raises busy, BUSY_WAIT=4 -> tx_err pulse 4 cycles after WAIT_START entry, return to IDLE, no second byte sent.
REQ-033 Reset mid-frame: assert rst during WAIT_DONE of the ALU first byte -> outputs reach reset values without a clock, and byte 8'h12 is never loaded.
REQ-034 Busy held by a prior frame: tx_busy=1 at IDLE with rd_valid=1 -> no rd_ack until tx_busy=0, then grant on the next edge.

Source files
------------

// File: rtl/tx_frame_sched.sv
// Round-robin scheduler feeding ALU results (two bytes, LSB first) and
// register reads (one byte) into a single UART transmitter.
module tx_frame_sched #(
    parameter int BUSY_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] alu_out,
    input  logic        alu_valid,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_p_data,
    output logic        tx_data_valid,
    output logic        alu_ack,
    output logic        rd_ack,
    output logic        sched_busy,
    output logic        tx_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(BUSY_WAIT - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_hold, w_hold_nxt;
    logic        r_byte_sel, w_byte_sel_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_last_alu, w_last_alu_nxt;
    logic        r_cur_alu, w_cur_alu_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic        r_txv, w_txv_nxt;
    logic        r_alu_ack, w_alu_ack_nxt;
    logic        r_rd_ack, w_rd_ack_nxt;
    logic        r_err, w_err_nxt;
    logic        w_pick_alu;

    // ALU wins when alone, or on a tie when RD was granted last
    always_comb w_pick_alu = alu_valid && (!rd_valid || !r_last_alu);

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold;
        w_byte_sel_nxt = r_byte_sel;
        w_cnt_nxt      = r_cnt;
        w_last_alu_nxt = r_last_alu;
        w_cur_alu_nxt  = r_cur_alu;
        w_tx_data_nxt  = r_tx_data;
        w_txv_nxt      = 1'b0;
        w_alu_ack_nxt  = 1'b0;
        w_rd_ack_nxt   = 1'b0;
        w_err_nxt      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if ((alu_valid || rd_valid) && !tx_busy) begin
                    w_state_nxt    = S_LOAD;
                    w_byte_sel_nxt = 1'b0;
                    w_cur_alu_nxt  = w_pick_alu;
                    w_last_alu_nxt = w_pick_alu;
                    if (w_pick_alu) begin
                        w_hold_nxt    = alu_out;
                        w_alu_ack_nxt = 1'b1;
                    end else begin
                        w_hold_nxt   = {8'h00, rd_data};
                        w_rd_ack_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_txv_nxt     = 1'b1;
                w_tx_data_nxt = r_byte_sel ? r_hold[15:8] : r_hold[7:0];
                w_cnt_nxt     = 8'd0;
                w_state_nxt   = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == LP_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (r_cur_alu && !r_byte_sel) begin
                        w_byte_sel_nxt = 1'b1;
                        w_state_nxt    = S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_hold     <= 16'h0000;
            r_byte_sel <= 1'b0;
            r_cnt      <= 8'd0;
            r_last_alu <= 1'b0;
            r_cur_alu  <= 1'b0;
            r_tx_data  <= 8'h00;
            r_txv      <= 1'b0;
            r_alu_ack  <= 1'b0;
            r_rd_ack   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_byte_sel <= w_byte_sel_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_alu <= w_last_alu_nxt;
            r_cur_alu  <= w_cur_alu_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_txv      <= w_txv_nxt;
            r_alu_ack  <= w_alu_ack_nxt;
            r_rd_ack   <= w_rd_ack_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign tx_p_data     = r_tx_data;
    assign tx_data_valid = r_txv;
    assign alu_ack       = r_alu_ack;
    assign rd_ack        = r_rd_ack;
    assign tx_err        = r_err;
    assign sched_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched with a simple UART busy model
// and a negedge monitor that logs frames, acks and pulse widths.
module tb_tx_frame_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] alu_out = 16'h0000;
    logic        alu_valid = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_valid = 1'b0;
    logic        tx_busy;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        alu_ack;
    logic        rd_ack;
    logic        sched_busy;
    logic        tx_err;

    int total = 0;
    int bad = 0;

    tx_frame_sched #(.BUSY_WAIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .alu_out(alu_out),
        .alu_valid(alu_valid),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .tx_busy(tx_busy),
        .tx_p_data(tx_p_data),
        .tx_data_valid(tx_data_valid),
        .alu_ack(alu_ack),
        .rd_ack(rd_ack),
        .sched_busy(sched_busy),
        .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    // Transmitter: busy one cycle after a load, for 11 cycles
    bit tx_mode = 1'b1;
    bit force_busy = 1'b0;
    int m_cnt = 0;
    always @(posedge clk) begin
        if (tx_mode && tx_data_valid) m_cnt <= 11;
        else if (m_cnt > 0) m_cnt <= m_cnt - 1;
    end
    assign tx_busy = force_busy || (m_cnt != 0);

    logic [7:0] frames[$];
    int vcyc[$];
    int cyc = 0;
    int n_alu = 0, n_rd = 0, n_err = 0, n_double = 0;
    bit p_v = 0, p_a = 0, p_r = 0, p_e = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_data_valid) begin
            frames.push_back(tx_p_data);
            vcyc.push_back(cyc);
        end
        if (alu_ack) n_alu++;
        if (rd_ack) n_rd++;
        if (tx_err) n_err++;
        if ((tx_data_valid && p_v) || (alu_ack && p_a) ||
            (rd_ack && p_r) || (tx_err && p_e)) n_double++;
        p_v = tx_data_valid;
        p_a = alu_ack;
        p_r = rd_ack;
        p_e = tx_err;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    task automatic run_until_idle(input string tag, input int max, output int gaps);
        bit acked = 0;
        bit done = 0;
        gaps = 0;
        for (int i = 0; i < max && !done; i++) begin
            @(negedge clk);
            if (alu_ack) begin alu_valid = 1'b0; acked = 1; end
            if (rd_ack) begin rd_valid = 1'b0; acked = 1; end
            if (!alu_valid && !rd_valid && !sched_busy && !tx_busy) done = 1;
            else if (acked && !sched_busy) gaps++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_idle: still busy after %0d cycles, required idle", tag, max);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        alu_valid = 1'b0;
        rd_valid = 1'b0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        total++;
        if ({tx_p_data, tx_data_valid, alu_ack, rd_ack, sched_busy, tx_err} !== 13'h0) begin
            bad++;
            $display("FAIL reset_async: got %h required 0",
                     {tx_p_data, tx_data_valid, alu_ack, rd_ack, sched_busy, tx_err});
        end
        @(negedge clk);
        total++;
        if ({tx_p_data, tx_data_valid, alu_ack, rd_ack, sched_busy, tx_err} !== 13'h0) begin
            bad++;
            $display("FAIL reset_held: got %h required 0",
                     {tx_p_data, tx_data_valid, alu_ack, rd_ack, sched_busy, tx_err});
        end
        rst = 1'b1;
    endtask

    task automatic test_single_rd();
        int f0 = frames.size();
        int r0 = n_rd;
        int a0 = n_alu;
        int g;
        rd_data = 8'hA5;
        rd_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({rd_ack, alu_ack, sched_busy, tx_data_valid} !== 4'b1010) begin
            bad++;
            $display("FAIL rd_grant: got %b required 1010",
                     {rd_ack, alu_ack, sched_busy, tx_data_valid});
        end
        rd_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({tx_data_valid, rd_ack, tx_p_data} !== {2'b10, 8'hA5}) begin
            bad++;
            $display("FAIL rd_load: got v=%b ack=%b d=%h required v=1 ack=0 d=a5",
                     tx_data_valid, rd_ack, tx_p_data);
        end
        repeat (4) @(negedge clk);
        total++;
        if ({tx_busy, tx_data_valid, sched_busy, tx_p_data} !== {3'b101, 8'hA5}) begin
            bad++;
            $display("FAIL rd_hold: got b=%b v=%b s=%b d=%h required b=1 v=0 s=1 d=a5",
                     tx_busy, tx_data_valid, sched_busy, tx_p_data);
        end
        run_until_idle("rd", 100, g);
        total++;
        if (frames.size() - f0 != 1 || frames[f0] !== 8'hA5) begin
            bad++;
            $display("FAIL rd_frames: got n=%0d first=%h required n=1 first=a5",
                     frames.size() - f0, frames[f0]);
        end
        total++;
        if (n_rd - r0 != 1 || n_alu - a0 != 0) begin
            bad++;
            $display("FAIL rd_acks: got rd=%0d alu=%0d required rd=1 alu=0",
                     n_rd - r0, n_alu - a0);
        end
    endtask

    task automatic test_alu();
        int f0 = frames.size();
        int v0 = vcyc.size();
        int a0 = n_alu;
        int r0 = n_rd;
        int e0 = n_err;
        int g;
        alu_out = 16'h1234;
        alu_valid = 1'b1;
        run_until_idle("alu", 200, g);
        total++;
        if (frames.size() - f0 != 2 || frames[f0] !== 8'h34 || frames[f0+1] !== 8'h12) begin
            bad++;
            $display("FAIL alu_frames: got n=%0d %h %h required n=2 34 12",
                     frames.size() - f0, frames[f0], frames[f0+1]);
        end
        total++;
        if (n_alu - a0 != 1 || n_rd - r0 != 0 || n_err - e0 != 0) begin
            bad++;
            $display("FAIL alu_acks: got alu=%0d rd=%0d err=%0d required 1 0 0",
                     n_alu - a0, n_rd - r0, n_err - e0);
        end
        total++;
        if (g != 0) begin
            bad++;
            $display("FAIL alu_sched_busy: got %0d idle cycles required 0", g);
        end
        total++;
        if (vcyc[v0+1] - vcyc[v0] != 14) begin
            bad++;
            $display("FAIL alu_gap: got %0d cycles between loads required 14",
                     vcyc[v0+1] - vcyc[v0]);
        end
    endtask

    task automatic test_tie();
        logic [7:0] exp1[5] = '{8'hEF, 8'hBE, 8'h5A, 8'hDE, 8'hC0};
        logic [7:0] exp2[3] = '{8'h99, 8'h88, 8'h77};
        int f0;
        int a0;
        int r0;
        int g;
        apply_reset();
        f0 = frames.size();
        a0 = n_alu;
        r0 = n_rd;
        alu_out = 16'hBEEF;
        rd_data = 8'h5A;
        alu_valid = 1'b1;
        rd_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({alu_ack, rd_ack} !== 2'b10) begin
            bad++;
            $display("FAIL tie_first: got alu_ack,rd_ack=%b required 10", {alu_ack, rd_ack});
        end
        alu_valid = 1'b0;
        @(negedge clk);
        alu_out = 16'hC0DE;
        alu_valid = 1'b1;
        run_until_idle("tie", 400, g);
        total++;
        if (frames.size() - f0 != 5) begin
            bad++;
            $display("FAIL tie_count: got %0d frames required 5", frames.size() - f0);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (frames[f0+i] !== exp1[i]) begin
                bad++;
                $display("FAIL tie_frame%0d: got %h required %h", i, frames[f0+i], exp1[i]);
            end
        end
        total++;
        if (n_alu - a0 != 2 || n_rd - r0 != 1) begin
            bad++;
            $display("FAIL tie_acks: got alu=%0d rd=%0d required 2 1", n_alu - a0, n_rd - r0);
        end
        f0 = frames.size();
        alu_out = 16'h7788;
        rd_data = 8'h99;
        alu_valid = 1'b1;
        rd_valid = 1'b1;
        run_until_idle("tie2", 300, g);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (frames[f0+i] !== exp2[i]) begin
                bad++;
                $display("FAIL tie2_frame%0d: got %h required %h", i, frames[f0+i], exp2[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int f0 = frames.size();
        int e0 = n_err;
        tx_mode = 1'b0;
        alu_out = 16'h1234;
        alu_valid = 1'b1;
        @(negedge clk);
        total++;
        if (alu_ack !== 1'b1) begin
            bad++;
            $display("FAIL to_ack: got %b required 1", alu_ack);
        end
        alu_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({tx_data_valid, tx_p_data} !== {1'b1, 8'h34}) begin
            bad++;
            $display("FAIL to_load: got v=%b d=%h required v=1 d=34", tx_data_valid, tx_p_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({tx_err, sched_busy} !== 2'b01) begin
                bad++;
                $display("FAIL to_wait%0d: got err,busy=%b required 01", i, {tx_err, sched_busy});
            end
        end
        @(negedge clk);
        total++;
        if ({tx_err, sched_busy} !== 2'b10) begin
            bad++;
            $display("FAIL to_err: got err,busy=%b required 10", {tx_err, sched_busy});
        end
        repeat (10) @(negedge clk);
        total++;
        if (frames.size() - f0 != 1 || n_err - e0 != 1 || sched_busy !== 1'b0) begin
            bad++;
            $display("FAIL to_after: got frames=%0d errs=%0d busy=%b required 1 1 0",
                     frames.size() - f0, n_err - e0, sched_busy);
        end
        tx_mode = 1'b1;
    endtask

    task automatic test_reset_mid();
        int f0 = frames.size();
        int r0 = n_rd;
        bit ok = 0;
        int g;
        alu_out = 16'h1234;
        alu_valid = 1'b1;
        @(negedge clk);
        alu_valid = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (tx_busy) ok = 1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL mid_busy: got busy=0 after 10 cycles required 1");
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_data = 8'h42;
        rd_valid = 1'b1;
        #1;
        total++;
        if ({tx_p_data, tx_data_valid, alu_ack, rd_ack, sched_busy, tx_err} !== 13'h0) begin
            bad++;
            $display("FAIL mid_reset: got %h required 0",
                     {tx_p_data, tx_data_valid, alu_ack, rd_ack, sched_busy, tx_err});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_until_idle("mid", 100, g);
        total++;
        if (frames.size() - f0 != 2 || frames[f0] !== 8'h34 || frames[f0+1] !== 8'h42) begin
            bad++;
            $display("FAIL mid_frames: got n=%0d %h %h required n=2 34 42",
                     frames.size() - f0, frames[f0], frames[f0+1]);
        end
        total++;
        if (n_rd - r0 != 1) begin
            bad++;
            $display("FAIL mid_rd_ack: got %0d required 1", n_rd - r0);
        end
    endtask

    task automatic test_busy_held();
        int f0 = frames.size();
        int g;
        force_busy = 1'b1;
        rd_data = 8'h3C;
        rd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({rd_ack, sched_busy} !== 2'b00) begin
                bad++;
                $display("FAIL held%0d: got ack,busy=%b required 00", i, {rd_ack, sched_busy});
            end
        end
        force_busy = 1'b0;
        @(negedge clk);
        total++;
        if (rd_ack !== 1'b1) begin
            bad++;
            $display("FAIL held_grant: got rd_ack=%b required 1", rd_ack);
        end
        rd_valid = 1'b0;
        run_until_idle("held", 100, g);
        total++;
        if (frames.size() - f0 != 1 || frames[f0] !== 8'h3C) begin
            bad++;
            $display("FAIL held_frames: got n=%0d %h required n=1 3c",
                     frames.size() - f0, frames[f0]);
        end
    endtask

    task automatic test_pulses();
        total++;
        if (n_double != 0) begin
            bad++;
            $display("FAIL pulse_width: got %0d double-wide pulses required 0", n_double);
        end
    endtask

    initial begin
        test_reset();
        test_single_rd();
        test_alu();
        test_tie();
        test_timeout();
        test_reset_mid();
        test_busy_held();
        test_pulses();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
